fcmp_pipe: RTL and testbench

- Pipelined floating-point compare/select unit for single-precision operands.
- Produces feq/flt/fle flags (0 or 1 in the 32-bit result) and fmin/fmax selections.
- Valid/ready handshake on both ends; sits between the FPU issue stage and the writeback arbiter.
- Two-stage pipeline with per-stage stall and bubble collapse; an optional tag rides alongside each operation.

---
 rtl/fcmp_pipe.sv | 142 ++++++++++++++
 tb/tb_fcmp_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage single-precision compare/select unit (feq/flt/fle/fmin/fmax).
// Operands are mapped to an unsigned ordering key in stage 1. The result is computed
// and registered in stage 2. Valid/ready handshake on both sides, with bubble collapse.
// Optional NaN handling is enabled by defining FCMP_NAN_EN. In the default build,
// NaNs are ordered by key like any other pattern and nan_o is tied low.
module fcmp_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] tag_out,
    output logic             nan_o
);

    localparam logic [2:0] OP_FEQ  = 3'b000;
    localparam logic [2:0] OP_FLT  = 3'b001;
    localparam logic [2:0] OP_FLE  = 3'b010;
    localparam logic [2:0] OP_FMIN = 3'b011;
    localparam logic [2:0] OP_FMAX = 3'b100;

    // Zero (any sign, denormals included) maps to the midpoint. Positives sit above it,
    // negatives sit below it with magnitude order reversed.
    function automatic logic [31:0] fkey(input logic [31:0] x);
        logic [31:0] k;
        if (x[30:23] == 8'd0)
            k = 32'h8000_0000;
        else if (!x[31])
            k = {1'b1, x[30:23], x[22:0]};
        else
            k = {1'b0, ~x[30:23], ~x[22:0]};
        return k;
    endfunction

    logic             v1, v2;
    logic             s2_load, s1_adv, in_xfer;
    logic [31:0]      key1, key2, a1, a2;
    logic [2:0]       op1;
    logic [TAG_W-1:0] tag1;
    logic [31:0]      res;

    assign s2_load   = !v2 || out_ready;
    assign s1_adv    = v1 && s2_load;
    assign in_ready  = !v1 || s1_adv;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = v2;

`ifdef FCMP_NAN_EN
    logic nan_a1, nan_b1;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
    endfunction

    // Stage 1 NaN flags: captured with the operands
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            nan_a1 <= is_nan(x1);
            nan_b1 <= is_nan(x2);
        end
    end
`endif

    // Stage 1: capture keys, raw operands, op and tag on input transfer
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1 <= 1'b0;
        end else if (in_xfer) begin
            v1   <= 1'b1;
            key1 <= fkey(x1);
            key2 <= fkey(x2);
            a1   <= x1;
            a2   <= x2;
            op1  <= op;
            tag1 <= tag_in;
        end else if (s1_adv) begin
            v1 <= 1'b0;
        end
    end

    // Result function evaluated on stage-1 contents
    always_comb begin
        res = '0;
        case (op1)
            OP_FEQ:  res = {31'd0, key1 == key2};
            OP_FLT:  res = {31'd0, key1 <  key2};
            OP_FLE:  res = {31'd0, key1 <= key2};
            OP_FMIN: res = (key1 <= key2) ? a1 : a2;
            OP_FMAX: res = (key1 >= key2) ? a1 : a2;
            default: res = '0;
        endcase
`ifdef FCMP_NAN_EN
        if (nan_a1 || nan_b1) begin
            case (op1)
                OP_FEQ, OP_FLT, OP_FLE: res = '0;
                OP_FMIN, OP_FMAX: begin
                    if (nan_a1 && nan_b1) res = 32'h7fc0_0000;
                    else if (nan_a1)      res = a2;
                    else                  res = a1;
                end
                default: res = '0;
            endcase
        end
`endif
    end

    // Stage 2: result register; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v2      <= 1'b0;
            y       <= '0;
            tag_out <= '0;
        end else if (s1_adv) begin
            v2      <= 1'b1;
            y       <= res;
            tag_out <= tag1;
        end else if (out_ready) begin
            v2 <= 1'b0;
        end
    end

`ifdef FCMP_NAN_EN
    // Stage 2 NaN flag, aligned with y
    always_ff @(posedge clk) begin
        if (!rstn)
            nan_o <= 1'b0;
        else if (s1_adv)
            nan_o <= nan_a1 || nan_b1;
    end
`else
    assign nan_o = 1'b0;
`endif

endmodule

// File: tb/tb_fcmp_pipe.sv
// tb_fcmp_pipe: randomized scoreboard bench for fcmp_pipe, with directed cases for
// latency, special operands, stall ordering and mid-flight reset.
// The reference model orders operands by signed magnitude.
// Define FCMP_NAN_EN for both the bench and the RTL to check NaN handling.
module tb_fcmp_pipe;

    logic        clk, rstn, in_valid, in_ready, out_valid, out_ready, nan_o;
    logic [2:0]  op;
    logic [31:0] x1, x2, y;
    logic [3:0]  tag_in, tag_out;

    fcmp_pipe #(.TAG_W(4)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .x1(x1), .x2(x2), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .tag_out(tag_out), .nan_o(nan_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] y;
        logic [3:0]  tag;
        logic        nan;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_out = 0;
    logic        hold = 1'b0;
    logic [31:0] hy;
    logic [3:0]  ht;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Real-number ordering with flush-to-zero: value = sign * (exponent:mantissa)
    function automatic longint val(input logic [31:0] x);
        longint mag;
        if (x[30:23] == 8'd0) return 0;
        mag = longint'(x[30:0]);
        return x[31] ? -mag : mag;
    endfunction

    function automatic logic isnan(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] != 0);
    endfunction

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] t);
        exp_t   e;
        longint va, vb;
        va = val(a);
        vb = val(b);
        e.tag = t;
        e.nan = 1'b0;
        case (o)
            3'd0: e.y = (va == vb) ? 32'd1 : 32'd0;
            3'd1: e.y = (va <  vb) ? 32'd1 : 32'd0;
            3'd2: e.y = (va <= vb) ? 32'd1 : 32'd0;
            3'd3: e.y = (va <= vb) ? a : b;
            3'd4: e.y = (va >= vb) ? a : b;
            default: e.y = 32'd0;
        endcase
`ifdef FCMP_NAN_EN
        e.nan = isnan(a) || isnan(b);
        if (e.nan) begin
            if (o <= 3'd2) e.y = 32'd0;
            else if (o <= 3'd4) begin
                if (isnan(a) && isnan(b)) e.y = 32'h7fc00000;
                else if (isnan(a))        e.y = b;
                else                      e.y = a;
            end
        end
`endif
        return e;
    endfunction

    // One clock cycle: drive at negedge, sample 1ns later, score transfers before the posedge
    task automatic cycle(input logic iv, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t, input logic ordy,
                         output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid = iv; op = o; x1 = a; x2 = b; tag_in = t; out_ready = ordy;
        #1;
        if (hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_y", y, hy);
            check("hold_tag", tag_out, ht);
        end
        acc = iv && in_ready;
        if (acc) q.push_back(model(o, a, b, t));
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                check("extra_out", out_valid, 0);
            end else begin
                e = q.pop_front();
                check("out_y", y, e.y);
                check("out_tag", tag_out, e.tag);
                check("out_nan", nan_o, e.nan);
                n_out++;
            end
        end
        hold = out_valid && !ordy;
        hy = y;
        ht = tag_out;
    endtask

    task automatic run_one(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expy, input logic expnan);
        logic acc;
        cycle(1'b1, o, a, b, 4'h9, 1'b1, acc);
        check("dir_acc", acc, 1);
        cycle(1'b0, 3'd0, 0, 0, 4'h0, 1'b1, acc);
        check("dir_lat1", out_valid, 0);
        cycle(1'b0, 3'd0, 0, 0, 4'h0, 1'b1, acc);
        check("dir_lat2", out_valid, 1);
        check("dir_y", y, expy);
        check("dir_tag", tag_out, 4'h9);
        check("dir_nan", nan_o, expnan);
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r = {r[31], 31'd0};
            1: r[30:23] = 8'd0;
            2: r = {r[31], 8'hff, 23'd0};
            3: r[30:23] = 8'hff;
            default: r[30:23] = 8'(126 + $urandom_range(0, 3));
        endcase
        return r;
    endfunction

    initial begin
        logic        acc, saw_stall;
        logic [31:0] a, b;
        int          base, nxt;

        rstn = 1'b0; in_valid = 1'b0; op = 3'd0; x1 = '0; x2 = '0; tag_in = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_tag", tag_out, 0);
        check("rst_nan", nan_o, 0);
        @(negedge clk);
        rstn = 1'b1;

        run_one(3'b001, 32'h3f800000, 32'h40000000, 32'd1, 1'b0);
        run_one(3'b001, 32'h40000000, 32'h3f800000, 32'd0, 1'b0);
        run_one(3'b000, 32'h00000000, 32'h80000001, 32'd1, 1'b0);
        run_one(3'b010, 32'hc0000000, 32'hbf800000, 32'd1, 1'b0);
        run_one(3'b011, 32'hbf800000, 32'h3f800000, 32'hbf800000, 1'b0);
        run_one(3'b100, 32'hbf800000, 32'h3f800000, 32'h3f800000, 1'b0);
        run_one(3'b111, 32'hbf800000, 32'h3f800000, 32'd0, 1'b0);
        run_one(3'b011, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0);
        run_one(3'b011, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0);
        run_one(3'b100, 32'h00000005, 32'h80000000, 32'h00000005, 1'b0);
`ifdef FCMP_NAN_EN
        run_one(3'b001, 32'h7fc00000, 32'h3f800000, 32'd0, 1'b1);
        run_one(3'b100, 32'h7fc00000, 32'h3f800000, 32'h3f800000, 1'b1);
        run_one(3'b011, 32'h7fc00000, 32'hffc00001, 32'h7fc00000, 1'b1);
`else
        run_one(3'b001, 32'h7fc00000, 32'h3f800000, 32'd0, 1'b0);
        run_one(3'b100, 32'h7fc00000, 32'h3f800000, 32'h7fc00000, 1'b0);
`endif

        // Four tagged ops with the consumer stalled for cycles 3-6
        base = n_out;
        nxt = 1;
        saw_stall = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cycle(nxt <= 4, 3'd4, 32'h3f800000 + nxt, 32'h3f800000, 4'(nxt),
                  !(c >= 3 && c <= 6), acc);
            if (nxt <= 4 && !in_ready) saw_stall = 1'b1;
            if (acc) nxt++;
        end
        check("stall_in_ready_low", saw_stall, 1);
        check("stall_count", n_out - base, 4);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            a = rnd_fp();
            b = ($urandom_range(0, 5) == 0) ? a : rnd_fp();
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b, 4'($urandom),
                  $urandom_range(0, 2) != 0, acc);
        end
        for (int i = 0; i < 20 && q.size() > 0; i++)
            cycle(1'b0, 3'd0, 0, 0, 4'h0, 1'b1, acc);
        check("drain_empty", q.size(), 0);

        // Mid-flight reset: two ops in the pipe, then one reset edge
        cycle(1'b1, 3'd1, 32'h3f800000, 32'h40000000, 4'hA, 1'b0, acc);
        cycle(1'b1, 3'd1, 32'h40000000, 32'h3f800000, 4'hB, 1'b0, acc);
        @(negedge clk);
        rstn = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_y", y, 0);
        q.delete();
        hold = 1'b0;
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 3'd0, 0, 0, 4'h0, 1'b1, acc);
        run_one(3'b010, 32'h3f800000, 32'h3f800000, 32'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
